// File: rtl/io_input_ctrl.sv
// Memory-mapped input block: two 8-bit switch/key ports with synchronizer and
// debouncer, change-status register with read-to-clear, and a masked level interrupt.

module io_input_db #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic       io_clk,
  input  logic       reset,
  input  logic [7:0] raw,
  output logic [7:0] stable,
  output logic       chg_set_c
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [7:0]       s1;
  logic [7:0]       s2;
  logic [7:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic             at_max_c;
  logic             commit_c;

  assign at_max_c  = (cnt == CNT_MAX);
  assign commit_c  = (s2 == cand) && at_max_c;
  // Only a commit that actually moves the stable value is reported as a change.
  assign chg_set_c = commit_c && (cand != stable);

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      s1     <= 8'h00;
      s2     <= 8'h00;
      cand   <= 8'h00;
      cnt    <= '0;
      stable <= 8'h00;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (at_max_c) begin
        // Counter holds at its limit; stable keeps being refreshed with cand.
        stable <= cand;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

module io_input_ctrl #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] io_write_data,
  input  logic [7:0]  in_port0,
  input  logic [7:0]  in_port1,
  output logic [31:0] io_read_data,
  output logic        irq
);

  localparam logic [5:0] SEL_PORT0  = 6'b110000;
  localparam logic [5:0] SEL_PORT1  = 6'b110001;
  localparam logic [5:0] SEL_STATUS = 6'b110010;
  localparam logic [5:0] SEL_IER    = 6'b110011;

  logic [5:0] sel_c;
  logic [7:0] stable0;
  logic [7:0] stable1;
  logic [1:0] chg_set_c;
  logic [1:0] chg;
  logic [1:0] ier;
  logic       status_clr_c;
  logic       ier_wr_c;
  logic       unused_c;

  assign sel_c        = addr[7:2];
  assign status_clr_c = io_rd && (sel_c == SEL_STATUS);
  assign ier_wr_c     = io_wr && (sel_c == SEL_IER);
  assign unused_c     = ^{addr[31:8], addr[1:0], io_write_data[31:2]};

  io_input_db #(.DB_CYCLES(DB_CYCLES)) u_db0 (
    .io_clk    (io_clk),
    .reset     (reset),
    .raw       (in_port0),
    .stable    (stable0),
    .chg_set_c (chg_set_c[0])
  );

  io_input_db #(.DB_CYCLES(DB_CYCLES)) u_db1 (
    .io_clk    (io_clk),
    .reset     (reset),
    .raw       (in_port1),
    .stable    (stable1),
    .chg_set_c (chg_set_c[1])
  );

  // A new change on the same edge as a status read survives the clear.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      chg <= 2'b00;
      ier <= 2'b00;
    end else begin
      chg <= (chg & ~{2{status_clr_c}}) | chg_set_c;
      if (ier_wr_c) begin
        ier <= io_write_data[1:0];
      end
    end
  end

  always_comb begin
    io_read_data = 32'h0000_0000;
    case (sel_c)
      SEL_PORT0:  io_read_data = {24'h00_0000, stable0};
      SEL_PORT1:  io_read_data = {24'h00_0000, stable1};
      SEL_STATUS: io_read_data = {30'h0000_0000, chg};
      SEL_IER:    io_read_data = {30'h0000_0000, ier};
      default:    io_read_data = 32'h0000_0000;
    endcase
  end

  assign irq = |(chg & ier);

endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl: directed scenarios plus random stimulus, all checked
// against a run-length reference model of the synchronize/debounce/status rules.

module tb_io_input_ctrl;

  localparam int unsigned DB = 4;
  localparam logic [31:0] A_P0  = 32'h0000_00C0;
  localparam logic [31:0] A_P1  = 32'h0000_00C4;
  localparam logic [31:0] A_ST  = 32'h0000_00C8;
  localparam logic [31:0] A_IE  = 32'h0000_00CC;
  localparam logic [31:0] A_BAD = 32'h0000_00D0;

  logic        io_clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'h0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [31:0] io_write_data = 32'h0;
  logic [7:0]  in_port0 = 8'h00;
  logic [7:0]  in_port1 = 8'h00;
  logic [31:0] io_read_data;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  io_input_ctrl #(.DB_CYCLES(DB)) dut (
    .io_clk        (io_clk),
    .reset         (reset),
    .addr          (addr),
    .io_rd         (io_rd),
    .io_wr         (io_wr),
    .io_write_data (io_write_data),
    .in_port0      (in_port0),
    .in_port1      (in_port1),
    .io_read_data  (io_read_data),
    .irq           (irq)
  );

  always #5 io_clk = ~io_clk;

  // Reference model: raw values reach the debouncer two edges late; a value
  // that has been seen on DB+1 consecutive edges becomes the stable value.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [7:0] m_runv[2];
  int         m_run[2];
  logic [7:0] m_stable[2];
  logic [1:0] m_chg;
  logic [1:0] m_ier;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq0 = {8'h00, 8'h00};
    mq1 = {8'h00, 8'h00};
    for (int p = 0; p < 2; p++) begin
      m_runv[p]   = 8'h00;
      m_run[p]    = 1;
      m_stable[p] = 8'h00;
    end
    m_chg = 2'b00;
    m_ier = 2'b00;
  endtask

  task automatic model_step();
    logic [7:0] v[2];
    logic [1:0] set;
    logic [5:0] sel;
    sel  = addr[7:2];
    v[0] = mq0.pop_front();
    v[1] = mq1.pop_front();
    mq0.push_back(in_port0);
    mq1.push_back(in_port1);
    set = 2'b00;
    for (int p = 0; p < 2; p++) begin
      if (v[p] == m_runv[p]) begin
        if (m_run[p] < 1000) m_run[p]++;
      end else begin
        m_runv[p] = v[p];
        m_run[p]  = 1;
      end
      if (m_run[p] >= int'(DB) + 1) begin
        if (m_runv[p] != m_stable[p]) set[p] = 1'b1;
        m_stable[p] = m_runv[p];
      end
    end
    if (io_rd && sel == 6'b110010) m_chg = set;
    else                           m_chg = m_chg | set;
    if (io_wr && sel == 6'b110011) m_ier = io_write_data[1:0];
  endtask

  function automatic logic [31:0] exp_rdata();
    case (addr[7:2])
      6'b110000: return {24'h0, m_stable[0]};
      6'b110001: return {24'h0, m_stable[1]};
      6'b110010: return {30'h0, m_chg};
      6'b110011: return {30'h0, m_ier};
      default:   return 32'h0;
    endcase
  endfunction

  // One bus cycle: drive on negedge, compare combinational outputs, advance model on posedge.
  task automatic cycle(input logic [7:0] p0, input logic [7:0] p1, input logic [31:0] a,
                       input logic rd, input logic wr, input logic [31:0] wd);
    @(negedge io_clk);
    in_port0      = p0;
    in_port1      = p1;
    addr          = a;
    io_rd         = rd;
    io_wr         = wr;
    io_write_data = wd;
    #1;
    check("rdata", io_read_data, exp_rdata());
    check("irq", 32'(irq), 32'(|(m_chg & m_ier)));
    @(posedge io_clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic pulse_reset(input int n);
    @(negedge io_clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_rdata", io_read_data, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    repeat (n) @(posedge io_clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] r0, r1;
    int         h0, h1;
    logic [31:0] a;
    int         k;

    model_reset();
    in_port0 = 8'hA5;
    addr     = A_P0;
    #1;
    check("reset_p0", io_read_data, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    addr = A_ST;
    #1;
    check("reset_status", io_read_data, 32'h0);
    addr = A_P0;
    repeat (3) @(posedge io_clk);
    #1;
    reset = 1'b0;

    // Steady A5 from reset release commits on edge DB+3.
    repeat (DB + 2) cycle(8'hA5, 8'h00, A_P0, 1'b0, 1'b0, 32'h0);
    check("p0_before_commit", io_read_data, 32'h0);
    cycle(8'hA5, 8'h00, A_P0, 1'b0, 1'b0, 32'h0);
    check("p0_commit", io_read_data, 32'h0000_00A5);
    cycle(8'hA5, 8'h00, A_ST, 1'b0, 1'b0, 32'h0);
    check("status_chg0", io_read_data, 32'h1);
    cycle(8'hA5, 8'h00, A_ST, 1'b1, 1'b0, 32'h0);
    check("status_cleared", io_read_data, 32'h0);

    // Short pulse on port1 is filtered.
    repeat (3) cycle(8'hA5, 8'hFF, A_P1, 1'b0, 1'b0, 32'h0);
    repeat (8) cycle(8'hA5, 8'h00, A_P1, 1'b0, 1'b0, 32'h0);
    check("glitch_p1", io_read_data, 32'h0);
    cycle(8'hA5, 8'h00, A_ST, 1'b0, 1'b0, 32'h0);
    check("glitch_chg", io_read_data, 32'h0);

    // Interrupt on port1 change with only ier[1] enabled.
    cycle(8'hA5, 8'h00, A_IE, 1'b0, 1'b1, 32'hFFFF_FFF2);
    check("ier_write", io_read_data, 32'h2);
    repeat (DB + 2) cycle(8'hA5, 8'h3C, A_ST, 1'b0, 1'b0, 32'h0);
    check("irq_before", 32'(irq), 32'h0);
    cycle(8'hA5, 8'h3C, A_ST, 1'b0, 1'b0, 32'h0);
    check("irq_rise", 32'(irq), 32'h1);
    check("status_chg1", io_read_data, 32'h2);
    cycle(8'hA5, 8'h3C, A_ST, 1'b1, 1'b0, 32'h0);
    check("irq_fall", 32'(irq), 32'h0);

    // Set wins over clear on the same edge.
    repeat (DB + 3) cycle(8'h11, 8'h22, A_P0, 1'b0, 1'b0, 32'h0);
    cycle(8'h11, 8'h22, A_ST, 1'b0, 1'b0, 32'h0);
    check("status_both", io_read_data, 32'h3);
    repeat (DB + 2) cycle(8'h33, 8'h22, A_ST, 1'b0, 1'b0, 32'h0);
    cycle(8'h33, 8'h22, A_ST, 1'b1, 1'b0, 32'h0);
    check("set_wins", io_read_data, 32'h1);

    // Reset in the middle of a debounce discards the candidate.
    repeat (5) cycle(8'h5A, 8'h22, A_P0, 1'b0, 1'b0, 32'h0);
    pulse_reset(2);
    repeat (DB + 2) cycle(8'h5A, 8'h22, A_P0, 1'b0, 1'b0, 32'h0);
    check("rst_no_commit", io_read_data, 32'h0);
    cycle(8'h5A, 8'h22, A_P0, 1'b0, 1'b0, 32'h0);
    check("rst_commit", io_read_data, 32'h0000_005A);

    // Unmapped read has no effect.
    cycle(8'h5A, 8'h22, A_BAD, 1'b1, 1'b1, 32'h3);
    check("bad_addr", io_read_data, 32'h0);
    cycle(8'h5A, 8'h22, A_ST, 1'b0, 1'b0, 32'h0);
    check("bad_no_clear", io_read_data, 32'h3);

    // Random traffic with varying hold lengths on both ports.
    r0 = 8'h5A; r1 = 8'h22; h0 = 0; h1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (h0 == 0) begin
        if ($urandom_range(0, 3) != 0) r0 = 8'($urandom);
        h0 = $urandom_range(1, 10);
      end
      if (h1 == 0) begin
        if ($urandom_range(0, 3) != 0) r1 = 8'($urandom);
        h1 = $urandom_range(1, 10);
      end
      h0--;
      h1--;
      k = $urandom_range(0, 5);
      a = $urandom;
      if (k < 4) a[7:2] = 6'b110000 | 6'(k);
      cycle(r0, r1, a, ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0), $urandom);
      if ($urandom_range(0, 599) == 0) pulse_reset(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_input_ctrl.md
IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable cycles required before a port value commits; legal range 2..255.
REQ-002 io_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 addr  input  32  CPU byte address; only addr[7:2] decoded.
REQ-005 io_rd  input  1  read strobe, one cycle per CPU load.
REQ-006 io_wr  input  1  write strobe, one cycle per CPU store.
REQ-007 io_write_data  input  32  store data; only bits [1:0] used.
REQ-008 in_port0  input  8  raw asynchronous switch/key inputs, port 0.
REQ-009 in_port1  input  8  raw asynchronous switch/key inputs, port 1.
REQ-010 io_read_data  output  32  combinational read data.
REQ-011 irq  output  1  level interrupt request to CPU.

Function
REQ-012 Address map on addr[7:2] SHALL be: 6'b110000 port0 value, 6'b110001 port1 value, 6'b110010 status (read-to-clear), 6'b110011 interrupt enable (read/write).
REQ-013 Each port SHALL pass through a per-bit two-flop synchronizer (s1, s2) before any other logic.
REQ-014 Per port debouncer SHALL hold cand[7:0] and cnt: if s2 != cand then cand <= s2, cnt <= 0; else if cnt == DB_CYCLES-1 then commit; else cnt <= cnt+1.
REQ-015 Commit SHALL copy cand to the port's stable register; cnt SHALL saturate at DB_CYCLES-1 while input stays constant (no wrap).
REQ-016 A clean input step held indefinitely SHALL appear in stable on the (DB_CYCLES+3)th rising edge after the step (7 with default).
REQ-017 Any input toggle before commit SHALL restart cnt at 0; pulses shorter than DB_CYCLES+1 cycles after synchronization SHALL never reach stable.
REQ-018 A commit where cand differs from the old stable SHALL set status bit chg[n] (n = port number); a commit with equal value SHALL not set it.
REQ-019 io_read_data SHALL be {24'b0, stable0}, {24'b0, stable1}, {30'b0, chg1, chg0}, {30'b0, ier} for the four addresses, and 32'b0 for any other address.
REQ-020 Status read (io_rd=1, status address) SHALL return pre-clear value combinationally and clear chg on that clock edge.
REQ-021 Same-edge status clear and new chg set for a port SHALL leave that bit set (set wins); the other bit clears normally.
REQ-022 Write (io_wr=1, enable address) SHALL load ier <= io_write_data[1:0] on that edge; writes elsewhere SHALL be ignored; reads of non-status addresses SHALL have no side effect.
REQ-023 irq SHALL equal |(chg & ier), combinational from registers.
REQ-024 io_rd and io_wr asserted together SHALL each perform its own action independently.

Reset
REQ-025 While reset=1: s1, s2, cand, cnt, stable0, stable1, chg, ier SHALL be 0; io_read_data for valid addresses reads 0; irq = 0.
REQ-026 Reset asserted mid-debounce SHALL discard the pending candidate; after release, a nonzero steady input SHALL commit after DB_CYCLES+3 edges and set chg.

Verification
REQ-027 Reset, in_port0 = 8'hA5 steady from release -> stable0 = 8'hA5 and chg = 2'b01 exactly on edge 7, port0 read = 32'h000000A5.
REQ-028 in_port1 glitches 8'h00->8'hFF for 3 cycles then back -> stable1 stays 8'h00, chg[1] stays 0.
REQ-029 Write ier = 2'b10, port1 steps to 8'h3C -> irq rises on commit edge; status read returns 32'h2, irq falls next edge.
REQ-030 Port0 commit on same edge as status read with chg = 2'b11 -> chg becomes 2'b01.
REQ-031 Reset asserted with cnt = 2 on port0 -> all outputs 0 immediately; no commit until 7 edges after release.
REQ-032 Read addr[7:2] = 6'b110100 -> io_read_data = 0, state unchanged.
